// File: rtl/roc_pkg.sv
// Shared encodings for the ring-oscillator counter and its control-register decoder.
package roc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } roc_state_e;

  typedef enum logic [1:0] {
    MODE_STICKY   = 2'd0,
    MODE_ONESHOT  = 2'd1,
    MODE_PERIODIC = 2'd2,
    MODE_RSVD     = 2'd3
  } roc_mode_e;

  // Threshold mask: all ones in the low nbc bits except bits [1:0], i.e. (nbc-3) ones then 100.
  function automatic logic [31:0] roc_mask(input int unsigned nbc);
    return (32'hFFFF_FFFF >> (32 - nbc)) & ~32'h3;
  endfunction

  // The reserved encoding behaves as the legacy sticky mode.
  function automatic roc_mode_e roc_mode_norm(input logic [1:0] m);
    return (m == 2'd3) ? MODE_STICKY : roc_mode_e'(m);
  endfunction

endpackage

// File: rtl/roc_sat_cnt.sv
// Saturating up-counter; clear has priority over increment.
module roc_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up on inc, stick at all-ones, drop to zero on clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (inc && (cnt != '1)) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/roc_cnt_prog.sv
// Programmable-threshold RO counter: sticky / one-shot / periodic threshold modes,
// snapshot on stop, saturating count of threshold matches.
module roc_cnt_prog
  import roc_pkg::*;
#(
  parameter int Nbc = 14,
  parameter int Nwc = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           start,
  input  logic           stop,
  input  logic [1:0]     mode,
  input  logic [Nbc-1:0] sel_nbc,
  input  logic           count_en,
  output logic           busy,
  output logic           full,
  output logic           tick,
  output logic [Nbc-1:0] counter,
  output logic [Nbc-1:0] snap,
  output logic [Nwc-1:0] wraps
);

  localparam logic [Nbc-1:0] MASK = Nbc'(roc_mask(Nbc));

  roc_state_e     r_state, w_next;
  roc_mode_e      r_mode;
  logic [Nbc-1:0] r_thr;
  logic [Nbc-1:0] r_counter;
  logic [Nbc-1:0] r_snap;
  logic           r_full, r_tick, r_busy;
  logic           w_stop_act, w_cnt_act, w_match;

  // Edge priority: clear > start > stop > count. Stop only acts outside IDLE.
  assign w_stop_act = stop && (r_state != ST_IDLE);
  assign w_cnt_act  = !clear && !start && !w_stop_act && (r_state == ST_RUN) && count_en;
  assign w_match    = w_cnt_act && (r_counter == r_thr);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    if (clear)                                 w_next = ST_IDLE;
    else if (start)                            w_next = ST_RUN;
    else if (w_stop_act)                       w_next = ST_IDLE;
    else if (w_match && r_mode == MODE_ONESHOT) w_next = ST_DONE;
  end

  // Threshold/mode are frozen at start so mid-run register writes cannot disturb a measurement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_thr  <= MASK;
      r_mode <= MODE_STICKY;
    end else if (!clear && start) begin
      r_thr  <= MASK & sel_nbc;
      r_mode <= roc_mode_norm(mode);
    end
  end

  // Counter, snapshot, flags. Match is judged on the pre-increment value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_counter <= '0;
      r_snap    <= '0;
      r_full    <= 1'b0;
      r_tick    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_tick <= w_match;
      r_busy <= (w_next == ST_RUN);
      if (clear || start) begin
        r_counter <= '0;
        r_full    <= 1'b0;
      end else if (w_stop_act) begin
        r_snap <= r_counter;
      end else if (w_cnt_act) begin
        if (w_match) r_full <= 1'b1;
        if (w_match && r_mode == MODE_ONESHOT)       r_counter <= r_thr;
        else if (w_match && r_mode == MODE_PERIODIC) r_counter <= '0;
        else                                         r_counter <= r_counter + Nbc'(1);
      end
    end
  end

  roc_sat_cnt #(.W(Nwc)) u_wraps (
    .clk (clk),
    .rst (rst),
    .clr (clear || start),
    .inc (w_match),
    .cnt (wraps)
  );

  assign busy    = r_busy;
  assign full    = r_full;
  assign tick    = r_tick;
  assign counter = r_counter;
  assign snap    = r_snap;

endmodule

// File: tb/tb_roc_cnt_prog.sv
// Bench for roc_cnt_prog: directed scenarios plus randomized traffic against a behavioural model.
module tb_roc_cnt_prog;

  localparam int NBC  = 14;
  localparam int NWC  = 2;
  localparam int CMOD = 1 << NBC;
  localparam int WMAX = (1 << NWC) - 1;
  localparam int MASKV = (CMOD - 1) & ~3;

  logic            clk = 1'b0;
  logic            rst, clear, start, stop, count_en;
  logic [1:0]      mode;
  logic [NBC-1:0]  sel_nbc;
  logic            busy, full, tick;
  logic [NBC-1:0]  counter, snap;
  logic [NWC-1:0]  wraps;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: 0 idle, 1 run, 2 done.
  int m_state, m_cnt, m_thr, m_mode, m_snap, m_wraps, m_full, m_tick;

  always #5 clk = ~clk;

  roc_cnt_prog #(.Nbc(NBC), .Nwc(NWC)) dut (
    .clk(clk), .rst(rst), .clear(clear), .start(start), .stop(stop),
    .mode(mode), .sel_nbc(sel_nbc), .count_en(count_en),
    .busy(busy), .full(full), .tick(tick), .counter(counter), .snap(snap), .wraps(wraps)
  );

  function automatic void model_reset();
    m_state = 0; m_cnt = 0; m_thr = MASKV; m_mode = 0;
    m_snap = 0; m_wraps = 0; m_full = 0; m_tick = 0;
  endfunction

  function automatic void model_step();
    int match;
    m_tick = 0;
    if (clear) begin
      m_state = 0; m_cnt = 0; m_full = 0; m_wraps = 0;
    end else if (start) begin
      m_state = 1; m_cnt = 0; m_full = 0; m_wraps = 0;
      m_thr  = int'(sel_nbc) & MASKV;
      m_mode = (mode == 2'd3) ? 0 : int'(mode);
    end else if (stop && m_state != 0) begin
      m_snap = m_cnt; m_state = 0;
    end else if (m_state == 1 && count_en) begin
      match = (m_cnt == m_thr);
      if (match) begin
        m_tick = 1; m_full = 1;
        if (m_wraps < WMAX) m_wraps++;
      end
      if (match && m_mode == 1)      m_state = 2;
      else if (match && m_mode == 2) m_cnt = 0;
      else                           m_cnt = (m_cnt + 1) % CMOD;
    end
  endfunction

  // One clock: inputs set at negedge, model advanced at posedge, outputs settle by next negedge.
  task automatic cyc(input logic c, input logic s, input logic p, input logic e,
                     input logic [1:0] m, input logic [NBC-1:0] sel);
    clear = c; start = s; stop = p; count_en = e; mode = m; sel_nbc = sel;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 0; start = 0; stop = 0; count_en = 0; mode = 0; sel_nbc = '0;
    model_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy, full, tick, counter, snap, wraps} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%0b full=%0b tick=%0b cnt=%h snap=%h wraps=%0d, want all 0",
               busy, full, tick, counter, snap, wraps);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Mode 0 around the top of the range with thr = 0x3FFC.
  task automatic test_sticky_wrap();
    int nt;
    cyc(0, 1, 0, 0, 2'd0, 14'h3FFF);
    nt = 0;
    for (int i = 0; i < 16'h3FFD; i++) begin
      cyc(0, 0, 0, 1, 2'd0, 14'h0000);
      if (tick === 1'b1) nt++;
    end
    n_tests++;
    if (nt != 1 || full !== 1'b1 || counter !== 14'h3FFD || wraps !== 2'd1) begin
      n_fail++;
      $display("FAIL sticky_thr: ticks=%0d full=%0b cnt=%h wraps=%0d, want 1/1/3ffd/1", nt, full, counter, wraps);
    end
    repeat (3) cyc(0, 0, 0, 1, 2'd0, 14'h0000);
    n_tests++;
    if (full !== 1'b1 || counter !== 14'h0000 || busy !== 1'b1 || tick !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_wrap: full=%0b cnt=%h busy=%0b tick=%0b, want 1/0000/1/0", full, counter, busy, tick);
    end
  endtask

  task automatic test_periodic();
    cyc(0, 1, 0, 0, 2'd2, 14'h0007);
    for (int k = 1; k <= 15; k++) begin
      cyc(0, 0, 0, 1, 2'd0, 14'h3FFF); // mode/sel changes must be ignored mid-run
      n_tests++;
      if (tick !== ((k % 5) == 0) || counter !== 14'(k % 5)) begin
        n_fail++;
        $display("FAIL periodic_k%0d: tick=%0b cnt=%h, want %0b/%h", k, tick, counter, (k % 5) == 0, k % 5);
      end
    end
    n_tests++;
    if (wraps !== 2'd3 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL periodic_wraps: wraps=%0d full=%0b, want 3/1", wraps, full);
    end
  endtask

  task automatic test_oneshot();
    cyc(0, 1, 0, 0, 2'd1, 14'h0007);
    for (int k = 1; k <= 9; k++) begin
      cyc(0, 0, 0, 1, 2'd1, 14'h0007);
      n_tests++;
      if (busy !== (k < 5) || counter !== 14'((k < 5) ? k : 4) || tick !== (k == 5)) begin
        n_fail++;
        $display("FAIL oneshot_k%0d: busy=%0b cnt=%h tick=%0b", k, busy, counter, tick);
      end
    end
    cyc(0, 0, 1, 0, 2'd1, 14'h0007);
    n_tests++;
    if (snap !== 14'h0004 || busy !== 1'b0 || counter !== 14'h0004) begin
      n_fail++;
      $display("FAIL oneshot_stop: snap=%h busy=%0b cnt=%h, want 0004/0/0004", snap, busy, counter);
    end
    cyc(0, 0, 0, 1, 2'd0, 14'h0000); // idle: enable must not count
    n_tests++;
    if (counter !== 14'h0004 || tick !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: cnt=%h tick=%0b, want 0004/0", counter, tick);
    end
  endtask

  task automatic test_thr_zero();
    cyc(0, 1, 0, 0, 2'd2, 14'h0003);
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 0, 0, 1, 2'd2, 14'h0003);
      n_tests++;
      if (tick !== 1'b1 || counter !== '0 || wraps !== 2'((k < 3) ? k : 3)) begin
        n_fail++;
        $display("FAIL thr0_k%0d: tick=%0b cnt=%h wraps=%0d", k, tick, counter, wraps);
      end
    end
  endtask

  task automatic test_abort_and_clear();
    cyc(0, 1, 0, 0, 2'd0, 14'h3FFF);
    repeat (10) cyc(0, 0, 0, 1, 2'd0, 14'h0000);
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_tests++;
    if ({busy, full, tick, counter, snap, wraps} !== '0) begin
      n_fail++;
      $display("FAIL async_abort: busy=%0b cnt=%h snap=%h wraps=%0d, want all 0", busy, counter, snap, wraps);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 1, 0, 0, 2'd0, 14'h0007);
    repeat (3) cyc(0, 0, 0, 1, 2'd0, 14'h0007);
    cyc(1, 1, 0, 1, 2'd0, 14'h0007);
    n_tests++;
    if (busy !== 1'b0 || counter !== '0 || full !== 1'b0 || wraps !== '0) begin
      n_fail++;
      $display("FAIL clear_start: busy=%0b cnt=%h full=%0b wraps=%0d, want 0/0/0/0", busy, counter, full, wraps);
    end
  endtask

  task automatic test_random();
    logic c, s, p, e;
    logic [1:0] m;
    logic [NBC-1:0] sel;
    for (int i = 0; i < 1500; i++) begin
      c = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 4);
      p = ($urandom_range(0, 99) < 4);
      e = ($urandom_range(0, 99) < 80);
      m = 2'($urandom_range(0, 3));
      sel = ($urandom_range(0, 3) == 0) ? NBC'($urandom) : NBC'($urandom_range(0, 31));
      cyc(c, s, p, e, m, sel);
      n_tests++;
      if (busy !== (m_state == 1) || full !== m_full[0] || tick !== m_tick[0] ||
          counter !== NBC'(m_cnt) || snap !== NBC'(m_snap) || wraps !== NWC'(m_wraps)) begin
        n_fail++;
        $display("FAIL random_%0d: got b%0b f%0b t%0b c%h s%h w%0d want b%0b f%0b t%0b c%h s%h w%0d",
                 i, busy, full, tick, counter, snap, wraps,
                 m_state == 1, m_full, m_tick, m_cnt, m_snap, m_wraps);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sticky_wrap();
    test_periodic();
    test_oneshot();
    test_thr_zero();
    test_abort_and_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/roc_cnt_prog.md
ROC_CNT_PROG -- requirements
Module: roc_cnt_prog

Interface
REQ-001 SHALL have parameter Nbc, default 14, meaning counter width in bits (legal 4..32).
REQ-002 SHALL have parameter Nwc, default 8, meaning width of the saturating wrap counter (legal 1..16).
REQ-003 SHALL have port clk  input  1  clock (single RO-derived clock; all logic on its rising edge).
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port clear  input  1  synchronous soft clear.
REQ-006 SHALL have port start  input  1  arm/restart a measurement.
REQ-007 SHALL have port stop  input  1  end measurement and capture snapshot.
REQ-008 SHALL have port mode  input  2  0 legacy sticky, 1 one-shot, 2 periodic, 3 treated as 0.
REQ-009 SHALL have port sel_nbc  input  Nbc  threshold select mask.
REQ-010 SHALL have port count_en  input  1  count enable.
REQ-011 SHALL have port busy  output  1  high while in RUN.
REQ-012 SHALL have port full  output  1  sticky threshold-reached flag.
REQ-013 SHALL have port tick  output  1  one-cycle pulse per threshold match.
REQ-014 SHALL have port counter  output  Nbc  live count.
REQ-015 SHALL have port snap  output  Nbc  counter value captured on stop.
REQ-016 SHALL have port wraps  output  Nwc  saturating count of threshold matches.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE; busy = (state == RUN).
REQ-018 SHALL compute effective threshold thr = MASK & sel_nbc, MASK = (Nbc-3) ones followed by binary 100, latching thr and mode on start; later changes to sel_nbc/mode are ignored until the next start.
REQ-019 SHALL apply per-edge priority clear > start > stop > count.
REQ-020 clear: any state -> IDLE; counter, full, tick, wraps to 0; snap retained.
REQ-021 start: any state -> RUN; counter, full, wraps to 0; no count that cycle.
REQ-022 stop: RUN or DONE -> IDLE; snap <= current counter (pre-update); no count that cycle; stop in IDLE ignored.
REQ-023 Count only in RUN with count_en=1; match = (counter == thr) evaluated on pre-increment value.
REQ-024 On match: tick=1 for exactly the following cycle; wraps += 1 saturating at all-ones; full <= 1.
REQ-025 Mode 0: counter increments every enabled cycle, wraps modulo 2^Nbc; full sticky; stays RUN.
REQ-026 Mode 1: on match counter holds thr, state -> DONE; DONE ignores count_en.
REQ-027 Mode 2: on match counter <= 0 instead of incrementing; stays RUN; full sticky.
REQ-028 thr = 0 is legal: mode 2 then ticks every enabled cycle with counter held at 0.
REQ-029 All outputs SHALL be registered; tick/full visible one edge after the matching enabled edge.

Reset
REQ-030 rst asynchronously forces IDLE, counter=0, snap=0, wraps=0, full=0, tick=0, busy=0, latched thr=MASK, latched mode=0.
REQ-031 rst asserted mid-RUN SHALL abort without snapshot; first start after rst release behaves per REQ-021.

Structure
REQ-032 Mode encodings, FSM state encodings and the MASK construction SHALL live in shared package roc_pkg for reuse by the TRNG control-register decoder.
REQ-033 Saturating wrap counter SHALL be one sub-module roc_sat_cnt (width Nwc, inc, clr, async rst); remainder flat.

Verification
REQ-034 Nbc=14, mode 0, sel_nbc=0x3FFF (thr=0x3FFC), start, 0x3FFD enabled cycles -> full=1, one tick, counter=0x3FFD, wraps=1; 3 more -> full still 1, counter=0x0000 after remaining wrap cycles.
REQ-035 mode 2, sel_nbc=0x0007 (thr=0x0004), start, 15 enabled cycles -> tick pulses on enables 5,10,15; counter sequence 1,2,3,4,0; wraps=3.
REQ-036 mode 1, thr=0x0004, 9 enabled cycles -> state DONE after 5th, counter frozen 0x0004, busy=0; stop -> snap=0x0004, IDLE.
REQ-037 Nwc=2, mode 2, sel_nbc=0x0003 (thr=0), 5 enabled cycles -> tick every cycle, counter=0, wraps saturates at 3.
REQ-038 mode 0, 10 enables then rst pulse mid-RUN -> all outputs 0, snap=0; same-cycle clear+start -> IDLE, counter 0.
